// File: rtl/tnn_stream_classifier.sv
// Serial ternary-weight classifier: accumulates N_IN weighted features and thresholds the sum.
// Define TNN_ACC_SAT_EN to replace the wrapping accumulator with a saturating one that reports clamps on out_sat_o.
module tnn_stream_classifier #(
   parameter int                       IN_W    = 2,
   parameter int                       N_IN    = 8,
   parameter int                       ACC_W   = 8,
   parameter logic [2*N_IN-1:0]        WEIGHTS = 16'h777D,
   parameter logic signed [ACC_W-1:0]  THRESH  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_class,
   output logic             out_sat,
   output logic [ACC_W-1:0] out_acc
);

   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCUM  = 2'd1;
   localparam logic [1:0] ST_RESULT = 2'd2;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             sat_q, sat_d;
   logic             out_valid_q, out_valid_d;
   logic             out_class_q, out_class_d;
   logic             out_sat_q, out_sat_d;
   logic [ACC_W-1:0] out_acc_q, out_acc_d;

   logic [1:0]       w_s;
   logic [ACC_W-1:0] feat_s;
   logic [ACC_W-1:0] term_s;
   logic [ACC_W-1:0] sum_s;
   logic             clamp_s;
   logic             xfer_s;

   assign in_ready  = (state_q != ST_RESULT);
   assign xfer_s    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_class = out_class_q;
   assign out_sat   = out_sat_q;
   assign out_acc   = out_acc_q;

   always_comb begin
      feat_s = ACC_W'(in_data);
      w_s    = WEIGHTS[{idx_q, 1'b0} +: 2];
      case (w_s)
         2'b01:   term_s = feat_s;
         2'b11:   term_s = {ACC_W{1'b0}} - feat_s;
         default: term_s = {ACC_W{1'b0}};
      endcase
   end

`ifdef TNN_ACC_SAT_EN
   // Returns {clamped, value}; the add is done one bit wider so overflow is visible.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W:0] wide;
      wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (wide[ACC_W] != wide[ACC_W-1])
         sat_add = {1'b1, wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
      else
         sat_add = {1'b0, wide[ACC_W-1:0]};
   endfunction

   assign {clamp_s, sum_s} = sat_add(acc_q, term_s);
`else
   assign sum_s   = acc_q + term_s;
   assign clamp_s = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      out_class_d = out_class_q;
      out_sat_d   = out_sat_q;
      out_acc_d   = out_acc_q;
      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (flush) begin
               // Abort wins over a coincident transfer, which is dropped.
               state_d = ST_IDLE;
               acc_d   = {ACC_W{1'b0}};
               idx_d   = {IDX_W{1'b0}};
               sat_d   = 1'b0;
            end else if (xfer_s) begin
               acc_d = sum_s;
               sat_d = sat_q | clamp_s;
               if (idx_q == IDX_LAST) begin
                  state_d     = ST_RESULT;
                  out_valid_d = 1'b1;
                  out_class_d = ($signed(sum_s) > THRESH);
                  out_sat_d   = sat_q | clamp_s;
                  out_acc_d   = sum_s;
               end else begin
                  state_d = ST_ACCUM;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_RESULT: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               acc_d       = {ACC_W{1'b0}};
               idx_d       = {IDX_W{1'b0}};
               sat_d       = 1'b0;
            end else begin
               state_d = ST_RESULT;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            acc_d       = {ACC_W{1'b0}};
            idx_d       = {IDX_W{1'b0}};
            sat_d       = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= {ACC_W{1'b0}};
         idx_q       <= {IDX_W{1'b0}};
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_class_q <= 1'b0;
         out_sat_q   <= 1'b0;
         out_acc_q   <= {ACC_W{1'b0}};
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         out_class_q <= out_class_d;
         out_sat_q   <= out_sat_d;
         out_acc_q   <= out_acc_d;
      end
   end

endmodule
